// File: rtl/exec_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : exec_seq_pkg
// Purpose  : Shared types and constants for the execution-stage address
//            sequencer: FSM state encoding, element field widths and the
//            per-core slot record unpacked from each memory element.
// Ports    : (package, none)
// Revision : 1.0 - initial release
// ============================================================================
package exec_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ADDR  = 3'd1,
      ST_MEM   = 3'd2,
      ST_ISSUE = 3'd3,
      ST_FIN   = 3'd4
   } seq_state_t;

   localparam int N_W    = 8;
   localparam int M_W    = 8;
   localparam int RNL_W  = 17;
   localparam int ELEM_W = 32;

   typedef struct packed {
      logic [N_W-1:0]   n;
      logic [M_W-1:0]   m;
      logic [RNL_W-1:0] rnl;
   } slot_t;

   // Element layout: [7:0] n, [15:8] m, [31:16] rn/lambda (zero-extended to 17 bits)
   function automatic slot_t unpackElem(input logic [ELEM_W-1:0] elem);
      slot_t s;
      s.n   = elem[7:0];
      s.m   = elem[15:8];
      s.rnl = {1'b0, elem[31:16]};
      return s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/exec_slot_reg.sv
`default_nettype none
// ============================================================================
// Module   : exec_slot_reg
// Purpose  : Single-slot capture register. Unpacks one 32-bit element into
//            the slot record when load is high; otherwise holds.
// Ports    : clkRD  - clock
//            rstRD  - asynchronous active-high reset
//            load   - capture enable
//            elem   - 32-bit element from the memory word
//            slot   - registered slot record {n, m, rnl}
// Revision : 1.0 - initial release
// ============================================================================
module exec_slot_reg
   import exec_seq_pkg::*;
(
   input  logic              clkRD,
   input  logic              rstRD,
   input  logic              load,
   input  logic [ELEM_W-1:0] elem,
   output slot_t             slot
);

   always_ff @(posedge clkRD or posedge rstRD) begin
      if (rstRD) begin
         slot <= '0;
      end else if (load) begin
         slot <= unpackElem(elem);
      end
   end

endmodule
`default_nettype wire

// File: rtl/exec_addr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : exec_addr_sequencer
// Purpose  : Walks the element memory from address 0 to lenM-1, waits
//            MEM_LAT cycles per read, unpacks each word into NCORE slots and
//            issues it to the execution cores with a vld/rdy handshake.
//            Optional continuous mode is built when SEQ_LOOP_EN is defined.
// Ports    : clkRD, rstRD (async, active-high)
//            start, abort, lenM, datomem, rdy, loop       - inputs
//            regdir, vld, n_o, m_o, rnl_o, busy, done,
//            pass_cnt                                     - outputs
// Macros   : SEQ_LOOP_EN - enables loop mode and the pass counter
// Revision : 1.0 - initial release
// ============================================================================
module exec_addr_sequencer
   import exec_seq_pkg::*;
#(
   parameter int NCORE   = 5,
   parameter int AW      = 7,
   parameter int WORD_W  = 800,
   parameter int MEM_LAT = 1
) (
   input  logic                   clkRD,
   input  logic                   rstRD,
   input  logic                   start,
   input  logic                   abort,
   input  logic [AW-1:0]          lenM,
   input  logic [WORD_W-1:0]      datomem,
   input  logic                   rdy,
   input  logic                   loop,
   output logic [AW-1:0]          regdir,
   output logic                   vld,
   output logic [N_W*NCORE-1:0]   n_o,
   output logic [M_W*NCORE-1:0]   m_o,
   output logic [RNL_W*NCORE-1:0] rnl_o,
   output logic                   busy,
   output logic                   done,
   output logic [7:0]             pass_cnt
);

   localparam logic [1:0] MEM_CNT_INIT = 2'(MEM_LAT - 1);

   seq_state_t    r_state;
   logic [AW-1:0] r_regdir;
   logic [AW-1:0] r_lenQ;
   logic [1:0]    r_memCnt;
   logic          r_vld;
   logic          r_busy;
   logic          r_done;
   logic          w_last;
   logic          w_load;

   // Widened by one bit so that regdir = 2^AW-1 cannot wrap past len_q.
   assign w_last = (({1'b0, r_regdir} + (AW+1)'(1)) >= {1'b0, r_lenQ});

   // Slot capture on the final latency cycle; abort wins so slots are kept.
   assign w_load = (r_state == ST_MEM) && (r_memCnt == 2'd0) && !abort;

`ifdef SEQ_LOOP_EN
   logic [7:0] r_passCnt;
   assign pass_cnt = r_passCnt;
`else
   logic w_unusedLoop;
   assign w_unusedLoop = loop;
   assign pass_cnt     = 8'd0;
`endif

   always_ff @(posedge clkRD or posedge rstRD) begin
      if (rstRD) begin
         r_state   <= ST_IDLE;
         r_regdir  <= '0;
         r_lenQ    <= '0;
         r_memCnt  <= 2'd0;
         r_vld     <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
`ifdef SEQ_LOOP_EN
         r_passCnt <= 8'd0;
`endif
      end else if (abort) begin
         r_state  <= ST_IDLE;
         r_regdir <= '0;
         r_vld    <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_lenQ    <= lenM;
                  r_done    <= 1'b0;
                  r_regdir  <= '0;
                  r_busy    <= 1'b1;
`ifdef SEQ_LOOP_EN
                  r_passCnt <= 8'd0;
`endif
                  r_state   <= (lenM == '0) ? ST_FIN : ST_ADDR;
               end
            end
            ST_ADDR: begin
               r_memCnt <= MEM_CNT_INIT;
               r_state  <= ST_MEM;
            end
            ST_MEM: begin
               if (r_memCnt == 2'd0) begin
                  r_vld   <= 1'b1;
                  r_state <= ST_ISSUE;
               end else begin
                  r_memCnt <= r_memCnt - 2'd1;
               end
            end
            ST_ISSUE: begin
               if (rdy) begin
                  r_vld <= 1'b0;
                  if (w_last) begin
`ifdef SEQ_LOOP_EN
                     if (r_passCnt != 8'hFF) begin
                        r_passCnt <= r_passCnt + 8'd1;
                     end
                     if (loop) begin
                        r_regdir <= '0;
                        r_state  <= ST_ADDR;
                     end else begin
                        r_state  <= ST_FIN;
                     end
`else
                     r_state <= ST_FIN;
`endif
                  end else begin
                     r_regdir <= r_regdir + AW'(1);
                     r_state  <= ST_ADDR;
                  end
               end
            end
            ST_FIN: begin
               r_done   <= 1'b1;
               r_regdir <= '0;
               r_busy   <= 1'b0;
               r_state  <= ST_IDLE;
            end
            default: begin
               r_vld   <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign regdir = r_regdir;
   assign vld    = r_vld;
   assign busy   = r_busy;
   assign done   = r_done;

   genvar gi;
   generate
      for (gi = 0; gi < NCORE; gi++) begin : g_slot
         slot_t w_slot;
         exec_slot_reg u_slot (
            .clkRD (clkRD),
            .rstRD (rstRD),
            .load  (w_load),
            .elem  (datomem[ELEM_W*gi +: ELEM_W]),
            .slot  (w_slot)
         );
         assign n_o[N_W*gi +: N_W]       = w_slot.n;
         assign m_o[M_W*gi +: M_W]       = w_slot.m;
         assign rnl_o[RNL_W*gi +: RNL_W] = w_slot.rnl;
      end
   endgenerate

   // Word bits above the populated slots carry nothing for this sequencer.
   generate
      if (WORD_W > ELEM_W*NCORE) begin : g_hiBits
         logic w_unusedHi;
         assign w_unusedHi = ^datomem[WORD_W-1:ELEM_W*NCORE];
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_exec_addr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_exec_addr_sequencer
// Purpose  : Self-checking bench for exec_addr_sequencer (NCORE=5, AW=7,
//            WORD_W=800, MEM_LAT=1). An expected-address queue plus a memory
//            image define what every issued word must look like; directed
//            tests pin timing, back-pressure, abort, reset and loop mode.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exec_addr_sequencer;
   localparam int NC = 5;
   localparam int AW = 7;
   localparam int WW = 800;
   localparam int ML = 1;

   logic            clkRD = 1'b0;
   logic            rstRD = 1'b1;
   logic            start = 1'b0;
   logic            abort = 1'b0;
   logic [AW-1:0]   lenM  = '0;
   logic [WW-1:0]   datomem;
   logic            rdy   = 1'b0;
   logic            loop  = 1'b0;
   logic [AW-1:0]   regdir;
   logic            vld;
   logic [8*NC-1:0] n_o;
   logic [8*NC-1:0] m_o;
   logic [17*NC-1:0] rnl_o;
   logic            busy;
   logic            done;
   logic [7:0]      pass_cnt;

   exec_addr_sequencer #(.NCORE(NC), .AW(AW), .WORD_W(WW), .MEM_LAT(ML)) dut (
      .clkRD(clkRD), .rstRD(rstRD), .start(start), .abort(abort), .lenM(lenM),
      .datomem(datomem), .rdy(rdy), .loop(loop), .regdir(regdir), .vld(vld),
      .n_o(n_o), .m_o(m_o), .rnl_o(rnl_o), .busy(busy), .done(done),
      .pass_cnt(pass_cnt)
   );

   always #5 clkRD = ~clkRD;

   // Asynchronous memory image addressed by regdir.
   logic [WW-1:0] memArr [0:127];
   assign datomem = memArr[regdir];

   int nChecks = 0;
   int nFails  = 0;
   int cyc     = 0;
   int kEdge   = 0;
   always @(posedge clkRD) cyc <= cyc + 1;

   // Model state
   int   expQ[$];
   int   vldTimes[$];
   int   vldRises = 0;
   int   doneRises = 0;
   int   hsCount = 0;
   logic prevVld = 1'b0;
   logic prevDone = 1'b0;
   logic [7:0]  capN2, capM2;
   logic [16:0] capR2;

   function automatic logic [8*NC-1:0] expN(input logic [WW-1:0] w);
      logic [8*NC-1:0] r;
      for (int i = 0; i < NC; i++) r[8*i +: 8] = w[32*i +: 8];
      return r;
   endfunction
   function automatic logic [8*NC-1:0] expM(input logic [WW-1:0] w);
      logic [8*NC-1:0] r;
      for (int i = 0; i < NC; i++) r[8*i +: 8] = w[32*i+8 +: 8];
      return r;
   endfunction
   function automatic logic [17*NC-1:0] expR(input logic [WW-1:0] w);
      logic [17*NC-1:0] r;
      for (int i = 0; i < NC; i++) r[17*i +: 17] = {1'b0, w[32*i+16 +: 16]};
      return r;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Compare process: every cycle vld is high, the issued word must be the
   // head of the expected-address queue with slots unpacked from memory.
   always @(negedge clkRD) begin
      if (rstRD) begin
         prevVld  = 1'b0;
         prevDone = 1'b0;
      end else begin
         if (vld && !prevVld) begin
            vldRises++;
            vldTimes.push_back(cyc - kEdge);
         end
         if (done && !prevDone) doneRises++;
         if (vld) begin
            if (expQ.size() == 0) begin
               check("unexpected_vld", {127'd0, vld}, 128'd0);
            end else begin
               check("issue_regdir", 128'(regdir), 128'(expQ[0]));
               check("issue_n", 128'(n_o), 128'(expN(memArr[expQ[0]])));
               check("issue_m", 128'(m_o), 128'(expM(memArr[expQ[0]])));
               check("issue_rnl", 128'(rnl_o), 128'(expR(memArr[expQ[0]])));
               if (regdir == 7'd1) begin
                  capN2 = n_o[23:16];
                  capM2 = m_o[23:16];
                  capR2 = rnl_o[50:34];
               end
               if (rdy) begin
                  void'(expQ.pop_front());
                  hsCount++;
               end
            end
         end
         prevVld  = vld;
         prevDone = done;
      end
   end

   task automatic step();
      @(posedge clkRD); #1;
   endtask

   task automatic startRun(input int len);
      lenM  = AW'(len);
      start = 1'b1;
      @(posedge clkRD); #1;
      kEdge = cyc;
      start = 1'b0;
      lenM  = 7'h55;   // must be ignored after acceptance
   endtask

   task automatic waitDone(input string name, input int budget, output int t);
      t = -1;
      for (int i = 0; i < budget; i++) begin
         step();
         if (done) begin
            t = cyc - kEdge;
            break;
         end
      end
      if (t < 0) check({name, "_done_timeout"}, 128'd0, 128'd1);
   endtask

   task automatic waitVld(input string name, input int budget);
      int ok = 0;
      for (int i = 0; i < budget; i++) begin
         step();
         if (vld) begin
            ok = 1;
            break;
         end
      end
      if (ok == 0) check({name, "_vld_timeout"}, 128'd0, 128'd1);
   endtask

   task automatic checkAllZero(input string name);
      check({name, "_regdir"}, 128'(regdir), 128'd0);
      check({name, "_vld"}, 128'(vld), 128'd0);
      check({name, "_busy"}, 128'(busy), 128'd0);
      check({name, "_done"}, 128'(done), 128'd0);
      check({name, "_pass_cnt"}, 128'(pass_cnt), 128'd0);
      check({name, "_n"}, 128'(n_o), 128'd0);
      check({name, "_m"}, 128'(m_o), 128'd0);
      check({name, "_rnl"}, 128'(rnl_o), 128'd0);
   endtask

   initial begin
      int t;
      int base;
      logic [AW-1:0]    holdAddr;
      logic [8*NC-1:0]  holdN;
      logic [17*NC-1:0] holdR;

      for (int a = 0; a < 128; a++)
         for (int e = 0; e < WW/32; e++)
            memArr[a][32*e +: 32] = $urandom();
      memArr[1][95:64] = 32'hABCD_1234;

      // Reset state
      repeat (3) @(posedge clkRD);
      #1;
      checkAllZero("reset");
      rstRD = 1'b0;

      // T1: lenM=3, rdy tied high; timing and slot unpacking literals
      rdy = 1'b1;
      vldTimes.delete();
      expQ = '{0, 1, 2};
      startRun(3);
      check("t1_busy", 128'(busy), 128'd1);
      waitDone("t1", 40, t);
      check("t1_vld_count", 128'(vldTimes.size()), 128'd3);
      check("t1_vld_time0", 128'(vldTimes[0]), 128'd2);
      check("t1_vld_time1", 128'(vldTimes[1]), 128'd5);
      check("t1_vld_time2", 128'(vldTimes[2]), 128'd8);
      check("t1_done_time", 128'(t), 128'd10);
      check("t1_queue_empty", 128'(expQ.size()), 128'd0);
      check("t1_regdir_fin", 128'(regdir), 128'd0);
      check("t1_busy_fin", 128'(busy), 128'd0);
      check("t1_slot2_n", 128'(capN2), 128'h34);
      check("t1_slot2_m", 128'(capM2), 128'h12);
      check("t1_slot2_rnl", 128'(capR2), 128'h0ABCD);

      // T2: lenM=0, no issue at all
      base = vldRises;
      startRun(0);
      check("t2_done_cleared", 128'(done), 128'd0);
      waitDone("t2", 10, t);
      check("t2_done_time", 128'(t), 128'd1);
      check("t2_no_vld", 128'(vldRises - base), 128'd0);
      check("t2_regdir", 128'(regdir), 128'd0);

      // T3: back-pressure for 10 cycles in ISSUE
      rdy  = 1'b0;
      expQ = '{0, 1, 2};
      startRun(3);
      waitVld("t3", 20);
      holdAddr = regdir;
      holdN    = n_o;
      holdR    = rnl_o;
      repeat (10) step();
      check("t3_vld_held", 128'(vld), 128'd1);
      check("t3_regdir_held", 128'(regdir), 128'(holdAddr));
      check("t3_n_held", 128'(n_o), 128'(holdN));
      check("t3_rnl_held", 128'(rnl_o), 128'(holdR));
      rdy = 1'b1;
      step();
      check("t3_vld_drop", 128'(vld), 128'd0);
      check("t3_regdir_adv", 128'(regdir), 128'(holdAddr) + 128'd1);
      waitDone("t3", 40, t);
      check("t3_queue_empty", 128'(expQ.size()), 128'd0);

      // T4: abort during MEM of the word at regdir 2, lenM=5
      expQ = '{0, 1};
      startRun(5);
      repeat (7) step();
      check("t4_pre_regdir", 128'(regdir), 128'd2);
      check("t4_pre_vld", 128'(vld), 128'd0);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("t4_regdir", 128'(regdir), 128'd0);
      check("t4_done", 128'(done), 128'd0);
      check("t4_busy", 128'(busy), 128'd0);
      check("t4_vld", 128'(vld), 128'd0);
      check("t4_slots_kept", 128'(n_o), 128'(expN(memArr[1])));
      check("t4_queue_empty", 128'(expQ.size()), 128'd0);
      repeat (3) step();
      check("t4_stays_idle", 128'(busy), 128'd0);

      // T5: reset pulse mid-ISSUE, then a full lenM=4 run
      rdy  = 1'b0;
      expQ = '{0, 1, 2, 3};
      startRun(4);
      waitVld("t5", 20);
      rstRD = 1'b1;
      #1;
      checkAllZero("t5_rst");
      expQ.delete();
      step();
      rstRD = 1'b0;
      rdy   = 1'b1;
      expQ  = '{0, 1, 2, 3};
      base  = vldRises;
      startRun(4);
      waitDone("t5", 60, t);
      check("t5_vld_count", 128'(vldRises - base), 128'd4);
      check("t5_queue_empty", 128'(expQ.size()), 128'd0);
      check("t5_done_time", 128'(t), 128'd13);

`ifdef SEQ_LOOP_EN
      // T6: loop mode, two looped passes then a final pass
      loop = 1'b1;
      expQ = '{0, 1, 0, 1, 0, 1};
      base = doneRises;
      t    = hsCount + 4;
      startRun(2);
      for (int i = 0; i < 60 && hsCount < t; i++) step();
      check("t6_loop_hs", 128'(hsCount >= t), 128'd1);
      check("t6_done_mid", 128'(done), 128'd0);
      check("t6_pass_mid", 128'(pass_cnt), 128'd2);
      loop = 1'b0;
      waitDone("t6", 40, t);
      check("t6_pass_cnt", 128'(pass_cnt), 128'd3);
      check("t6_done_rises", 128'(doneRises - base), 128'd1);
      check("t6_queue_empty", 128'(expQ.size()), 128'd0);
`else
      // T6: loop ignored without the option
      loop = 1'b1;
      expQ = '{0, 1};
      startRun(2);
      waitDone("t6", 40, t);
      check("t6_pass_cnt", 128'(pass_cnt), 128'd0);
      check("t6_done_time", 128'(t), 128'd7);
      check("t6_queue_empty", 128'(expQ.size()), 128'd0);
      loop = 1'b0;
`endif

      repeat (3) step();
      $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
      $finish;
   end

endmodule
`default_nettype wire
